// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter and its baud counter.
// State encoding, data/counter widths and the default bit period.
package fifo_uart_pkg;

   localparam int DATA_W           = 8;
   localparam int CLKS_PER_BIT_DEF = 868;
   localparam int SENT_W           = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_REQ    = 3'd1,
      S_LOAD   = 3'd2,
      S_START  = 3'd3,
      S_DATA   = 3'd4,
      S_STOP   = 3'd5,
      S_PARITY = 3'd6
   } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and flags the terminal count.
// A synchronous clear restarts the period; reused by the future RX stage.
module uart_baud_cnt
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = (cnt == TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto an 8N1 UART line, LSB first, with busy/done status
// and a frame counter. Define FIFO_UART_TX_PARITY_EN to add an even-parity bit.
module fifo_uart_tx
   import fifo_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fifo_empty,
   input  logic [DATA_W-1:0] fifo_data,
   output logic              fifo_rd_en,
   output logic              tx,
   output logic              busy,
   output logic              tx_done,
   output logic [SENT_W-1:0] sent_cnt
);

   localparam int BIT_W = $clog2(DATA_W);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

   state_t            state;
   state_t            state_next;
   logic [DATA_W-1:0] shift;
   logic [BIT_W-1:0]  bit_idx;
   logic              tick;
   logic              baud_clear;
`ifdef FIFO_UART_TX_PARITY_EN
   logic              parity;
`endif

   // Every state change restarts the bit period, so each state starts at count 0.
   assign baud_clear = (state_next != state);

   uart_baud_cnt #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (baud_clear),
      .tick  (tick)
   );

   always_comb begin
      state_next = state;
      tx         = 1'b1;
      fifo_rd_en = 1'b0;
      busy       = (state != S_IDLE);
      tx_done    = 1'b0;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) state_next = S_REQ;
         end
         S_REQ: begin
            fifo_rd_en = 1'b1;
            state_next = S_LOAD;
         end
         S_LOAD: begin
            state_next = S_START;
         end
         S_START: begin
            tx = 1'b0;
            if (tick) state_next = S_DATA;
         end
         S_DATA: begin
            tx = shift[0];
            if (tick && (bit_idx == LAST_BIT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
               state_next = S_PARITY;
`else
               state_next = S_STOP;
`endif
            end
         end
`ifdef FIFO_UART_TX_PARITY_EN
         S_PARITY: begin
            tx = parity;
            if (tick) state_next = S_STOP;
         end
`endif
         S_STOP: begin
            if (tick) begin
               tx_done    = 1'b1;
               state_next = S_IDLE;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // LOAD is the cycle the FIFO's registered read data is valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift   <= '0;
         bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity  <= 1'b0;
`endif
      end else if (state == S_LOAD) begin
         shift   <= fifo_data;
         bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
         parity  <= ^fifo_data;
`endif
      end else if ((state == S_DATA) && tick) begin
         shift   <= {1'b0, shift[DATA_W-1:1]};
         bit_idx <= bit_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sent_cnt <= '0;
      end else if (tx_done) begin
         sent_cnt <= sent_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised scoreboard bench for fifo_uart_tx: a FIFO model feeds bytes, a
// line monitor rebuilds each frame and checks it against the queued bytes.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME_CYC = NBITS * CPB;

   logic        clk        = 1'b0;
   logic        rst_n      = 1'b0;
   logic        fifo_empty = 1'b1;
   logic [7:0]  fifo_data  = 8'h00;
   logic        fifo_rd_en;
   logic        tx;
   logic        busy;
   logic        tx_done;
   logic [15:0] sent_cnt;

   int checks = 0;
   int errors = 0;

   byte unsigned fifo_q[$];
   byte unsigned exp_q[$];
   byte unsigned held;
   bit           rd_pending = 0;
   int           rd_pulses  = 0;

   bit           in_frame    = 0;
   int           mon_cyc     = 0;
   int           frames_done = 0;
   int           gap_cnt     = 0;
   int           last_gap    = 0;
   bit           have_exp;
   byte unsigned cur;
   logic [10:0]  act_bits;
   logic         bit_val;
   int           glitch;
   int           done_err;

   always #5 clk = ~clk;

   fifo_uart_tx #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done),
      .sent_cnt   (sent_cnt)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input byte unsigned b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
      fifo_empty = 1'b0;
   endtask

   // Reference frame: start 0, eight data bits LSB first, optional even parity, stop 1.
   function automatic logic [10:0] frame_bits(input byte unsigned b);
      logic [10:0] f;
      f    = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1 + i] = b[i];
`ifdef FIFO_UART_TX_PARITY_EN
      f[9] = ($countones(b) % 2) == 1;
`endif
      return f;
   endfunction

   task automatic waitDrain(input int budget);
      int  n    = 0;
      bit  done = 0;
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
         done = (fifo_q.size() == 0) && !rd_pending && !busy && !in_frame;
      end
      if (!done) checkOutput("drain_timeout", 32'(n), 32'(budget + 1));
   endtask

   // FIFO model: pops on a read strobe, presents the byte one cycle later, garbage otherwise.
   always @(negedge clk) begin
      if (rd_pending) begin
         fifo_data  = held;
         rd_pending = 0;
      end else begin
         fifo_data = 8'($urandom);
      end
      if (rst_n && fifo_rd_en) begin
         rd_pulses++;
         checkOutput("rd_en_nonempty", 32'(fifo_q.size() != 0), 32'd1);
         if (fifo_q.size() != 0) begin
            held       = fifo_q.pop_front();
            rd_pending = 1;
         end
         fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Line monitor: rebuilds each frame cycle by cycle and scores it.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame    = 0;
         mon_cyc     = 0;
         frames_done = 0;
         gap_cnt     = 0;
         checkOutput("reset_outputs", 32'({tx, fifo_rd_en, busy, tx_done, sent_cnt}), 32'h80000);
      end else begin
         if (!in_frame) begin
            if (tx === 1'b0) begin
               last_gap = gap_cnt;
               gap_cnt  = 0;
               have_exp = (exp_q.size() != 0);
               checkOutput("frame_expected", 32'(have_exp), 32'd1);
               if (have_exp) cur = exp_q.pop_front();
               checkOutput("sent_cnt_at_start", 32'(sent_cnt), 32'(frames_done));
               in_frame = 1;
               mon_cyc  = 0;
               act_bits = '1;
               glitch   = 0;
               done_err = 0;
            end else begin
               gap_cnt++;
               checkOutput("tx_done_idle", 32'(tx_done), 32'd0);
            end
         end
         if (in_frame) begin
            if (mon_cyc % CPB == 0) bit_val = tx;
            else if (tx !== bit_val) glitch++;
            if (mon_cyc % CPB == CPB / 2) act_bits[mon_cyc / CPB] = tx;
            if ((tx_done === 1'b1) != (mon_cyc == FRAME_CYC - 1)) done_err++;
            mon_cyc++;
            if (mon_cyc == FRAME_CYC) begin
               if (have_exp) checkOutput("frame_bits", 32'(act_bits), 32'(frame_bits(cur)));
               checkOutput("frame_glitch", 32'(glitch), 32'd0);
               checkOutput("tx_done_timing", 32'(done_err), 32'd0);
               frames_done++;
               in_frame = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int rp0;
      int viol;
      int lat;
      int pushed;
      int guard;

      // Reset with a byte waiting, then one 0xA5 frame.
      rst_n = 1'b0;
      applyStimulus(8'hA5);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      waitDrain(200);
      checkOutput("a5_rd_pulses", 32'(rd_pulses), 32'd1);
      checkOutput("a5_sent_cnt", 32'(sent_cnt), 32'd1);
      checkOutput("a5_busy_after", 32'(busy), 32'd0);

      // Back-to-back 0x00, 0xFF: three high cycles between frames.
      @(negedge clk);
      rp0 = rd_pulses;
      applyStimulus(8'h00);
      applyStimulus(8'hFF);
      waitDrain(400);
      checkOutput("b2b_rd_pulses", 32'(rd_pulses - rp0), 32'd2);
      checkOutput("b2b_gap", 32'(last_gap), 32'd3);
      checkOutput("b2b_sent_cnt", 32'(sent_cnt), 32'd3);

      // Long empty period: nothing moves.
      viol = 0;
      rp0  = rd_pulses;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (fifo_rd_en !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
      end
      checkOutput("empty_idle_violations", 32'(viol), 32'd0);
      checkOutput("empty_rd_pulses", 32'(rd_pulses - rp0), 32'd0);

      // Latency from fifo_empty falling to the start bit.
      applyStimulus(8'h5A);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (tx !== 1'b0 && lat < 20);
      checkOutput("start_latency", 32'(lat), 32'd3);
      waitDrain(200);
      checkOutput("lat_sent_cnt", 32'(sent_cnt), 32'd4);

      // Reset during data bit 3 of 0x3C drops the frame.
      applyStimulus(8'h3C);
      guard = 0;
      while (!(in_frame && mon_cyc >= 4 * CPB + 1) && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      checkOutput("reset_mid_reached", 32'(guard < 200), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("reset_mid_tx", 32'(tx), 32'd1);
      checkOutput("reset_mid_busy", 32'(busy), 32'd0);
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      checkOutput("post_reset_busy", 32'(busy), 32'd0);
      checkOutput("post_reset_sent_cnt", 32'(sent_cnt), 32'd0);

      // Parity corner bytes, then a randomised burst respecting the 8-deep FIFO.
      applyStimulus(8'h07);
      applyStimulus(8'h03);
      waitDrain(300);
      checkOutput("parity_bytes_sent", 32'(sent_cnt), 32'd2);

      pushed = 0;
      guard  = 0;
      while (pushed < 16 && guard < 3000) begin
         @(negedge clk);
         guard++;
         if (fifo_q.size() < 8 && $urandom_range(0, 3) == 0) begin
            applyStimulus(8'($urandom));
            pushed++;
         end
      end
      waitDrain(16 * (FRAME_CYC + 3) + 100);
      checkOutput("random_sent_cnt", 32'(sent_cnt), 32'd18);
      checkOutput("random_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
